// File: rtl/mod_exp_engine.sv
// -----------------------------------------------------------------------------
// mod_exp_engine
//   Computes value_in ^ exponent_in mod modulus_in with a right-to-left
//   square-and-multiply loop built around one shared bit-serial interleaved
//   modular multiplier.
//
// Ports
//   clk_in       clock
//   rst_in       synchronous active-high reset
//   ready_in     start request, sampled only while busy_out=0
//   abort_in     cancel the running operation (ignored while idle)
//   value_in     base, any value (reduced internally)
//   modulus_in   modulus m
//   exponent_in  exponent e
//   value_out    result (< m), held until the next completion
//   busy_out     operation in progress
//   valid_out    one-cycle completion pulse
//   error_out    qualifies valid_out: modulus was zero
//   state_out    current FSM state (debug)
//
// Handshake: a request is accepted on the rising edge where ready_in=1 and
// busy_out=0; operands are latched on that edge. busy_out stays high until
// the edge that raises valid_out for exactly one cycle, so a new request can
// be presented in the same cycle valid_out is high.
// -----------------------------------------------------------------------------
module mod_exp_engine #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 ready_in,
    input  logic                 abort_in,
    input  logic [WIDTH-1:0]     value_in,
    input  logic [WIDTH-1:0]     modulus_in,
    input  logic [EXP_WIDTH-1:0] exponent_in,
    output logic [WIDTH-1:0]     value_out,
    output logic                 busy_out,
    output logic                 valid_out,
    output logic                 error_out,
    output logic [2:0]           state_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REDUCE = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_MUL_R  = 3'd3;
    localparam logic [2:0] S_SQR    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH);

    logic [2:0]           state;
    logic [WIDTH-1:0]     mod_q;
    logic [WIDTH-1:0]     one_q;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     v_q;
    logic [EXP_WIDTH-1:0] e_q;
    logic                 err_q;

    // Multiplier datapath: cnt==0 is the load cycle, cnt=1..WIDTH are steps.
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;   // shifted left each step; MSB is current bit

    logic [WIDTH+1:0]     mod_ext;
    logic [WIDTH+1:0]     dbl;
    logic [WIDTH+1:0]     dbl_red;
    logic [WIDTH+1:0]     sum;
    logic [WIDTH-1:0]     acc_next;
    logic                 mul_state;
    logic                 mul_last;

    // One interleaved step: acc stays < m, so 2*acc < 2m and
    // (2*acc mod m) + a < 2m; both fit in WIDTH+2 bits for any m.
    always_comb begin
        mod_ext  = {2'b00, mod_q};
        dbl      = {1'b0, acc, 1'b0};
        dbl_red  = (dbl >= mod_ext) ? (dbl - mod_ext) : dbl;
        sum      = mul_b[WIDTH-1] ? (dbl_red + {2'b00, mul_a}) : dbl_red;
        acc_next = (sum >= mod_ext) ? WIDTH'(sum - mod_ext) : WIDTH'(sum);
    end

    assign mul_state = (state == S_REDUCE) || (state == S_MUL_R) || (state == S_SQR);
    assign mul_last  = (cnt == CNT_LAST);
    assign state_out = state;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= S_IDLE;
            mod_q     <= '0;
            one_q     <= '0;
            r_q       <= '0;
            b_q       <= '0;
            v_q       <= '0;
            e_q       <= '0;
            err_q     <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            value_out <= '0;
            busy_out  <= 1'b0;
            valid_out <= 1'b0;
            error_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            error_out <= 1'b0;
            if (busy_out && abort_in) begin
                // Abort wins over everything, including a pending DONE.
                state    <= S_IDLE;
                busy_out <= 1'b0;
                cnt      <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ready_in) begin
                            mod_q    <= modulus_in;
                            v_q      <= value_in;
                            e_q      <= exponent_in;
                            one_q    <= (modulus_in == WIDTH'(1)) ? '0 : WIDTH'(1);
                            r_q      <= (modulus_in == WIDTH'(1)) ? '0 : WIDTH'(1);
                            busy_out <= 1'b1;
                            cnt      <= '0;
                            // Zero modulus takes one CHECK cycle on the way
                            // to DONE so its latency is a fixed 2 cycles.
                            err_q    <= (modulus_in == '0);
                            state    <= (modulus_in == '0) ? S_CHECK : S_REDUCE;
                        end
                    end
                    S_CHECK: begin
                        if (err_q || (e_q == '0)) begin
                            state <= S_DONE;
                        end else if (e_q[0]) begin
                            state <= S_MUL_R;
                        end else begin
                            state <= S_SQR;
                        end
                    end
                    S_DONE: begin
                        value_out <= err_q ? '0 : r_q;
                        error_out <= err_q;
                        valid_out <= 1'b1;
                        busy_out  <= 1'b0;
                        state     <= S_IDLE;
                    end
                    default: begin
                        if (mul_state) begin
                            if (cnt == '0) begin
                                acc <= '0;
                                cnt <= CW'(1);
                                case (state)
                                    S_REDUCE: begin
                                        mul_a <= one_q;
                                        mul_b <= v_q;
                                    end
                                    S_MUL_R: begin
                                        mul_a <= r_q;
                                        mul_b <= b_q;
                                    end
                                    default: begin
                                        mul_a <= b_q;
                                        mul_b <= b_q;
                                    end
                                endcase
                            end else begin
                                acc   <= acc_next;
                                mul_b <= {mul_b[WIDTH-2:0], 1'b0};
                                cnt   <= cnt + CW'(1);
                                if (mul_last) begin
                                    cnt <= '0;
                                    case (state)
                                        S_REDUCE: begin
                                            b_q   <= acc_next;
                                            state <= S_CHECK;
                                        end
                                        S_MUL_R: begin
                                            r_q   <= acc_next;
                                            // Last exponent bit: skip the
                                            // useless final squaring.
                                            state <= ((e_q >> 1) == '0) ? S_DONE : S_SQR;
                                        end
                                        default: begin
                                            b_q   <= acc_next;
                                            e_q   <= e_q >> 1;
                                            state <= S_CHECK;
                                        end
                                    endcase
                                end
                            end
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod_exp_engine.sv
module tb_mod_exp_engine;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        ready_in;
    logic        abort_in;
    logic [15:0] value_in;
    logic [15:0] modulus_in;
    logic [15:0] exponent_in;
    logic [15:0] value_out;
    logic        busy_out;
    logic        valid_out;
    logic        error_out;
    logic [2:0]  state_out;

    int total = 0;
    int bad   = 0;

    mod_exp_engine #(.WIDTH(16), .EXP_WIDTH(16)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .ready_in    (ready_in),
        .abort_in    (abort_in),
        .value_in    (value_in),
        .modulus_in  (modulus_in),
        .exponent_in (exponent_in),
        .value_out   (value_out),
        .busy_out    (busy_out),
        .valid_out   (valid_out),
        .error_out   (error_out),
        .state_out   (state_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] v;
        logic [15:0] m;
        logic [15:0] e;
        logic [15:0] res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_res(input logic [15:0] v, input logic [15:0] m,
                                              input logic [15:0] e);
        longint r;
        longint b;
        if (m == 0) return 16'd0;
        r = 1 % longint'(m);
        b = longint'(v) % longint'(m);
        for (int i = 0; i < 16; i++) begin
            if (e[i]) r = (r * b) % longint'(m);
            b = (b * b) % longint'(m);
        end
        return 16'(r);
    endfunction

    function automatic int model_lat(input logic [15:0] m, input logic [15:0] e);
        int k;
        int p;
        k = 0;
        p = 0;
        if (m == 0) return 2;
        for (int i = 0; i < 16; i++) begin
            if (e[i]) begin
                k = i + 1;
                p++;
            end
        end
        return 17 * (1 + p + ((k > 0) ? k - 1 : 0)) + ((k > 0) ? k : 1) + 1;
    endfunction

    // Issue one request and follow it to completion, checking result,
    // error flag, latency, busy throughout and a single-cycle pulse.
    task automatic run_op(input string name, input logic [15:0] v, input logic [15:0] m,
                          input logic [15:0] e, input logic [15:0] exp_res,
                          input logic exp_err, input int exp_lat, input bit disturb);
        int  lat;
        int  guard;
        bit  seen;
        bit  busy_ok;
        guard = 0;
        while (busy_out && guard < 3000) begin
            @(posedge clk_in);
            #1;
            guard++;
        end
        @(negedge clk_in);
        value_in    = v;
        modulus_in  = m;
        exponent_in = e;
        ready_in    = 1'b1;
        @(posedge clk_in);
        #1;
        ready_in = 1'b0;
        lat      = 0;
        seen     = 1'b0;
        busy_ok  = 1'b1;
        while (!seen && lat < 3000) begin
            @(posedge clk_in);
            #1;
            lat++;
            if (valid_out) seen = 1'b1;
            else if (!busy_out) busy_ok = 1'b0;
            if (disturb && !seen && lat >= 5 && lat < 15) begin
                value_in    = 16'($urandom_range(0, 65535));
                modulus_in  = 16'($urandom_range(0, 65535));
                exponent_in = 16'($urandom_range(0, 65535));
                ready_in    = (lat < 14);
            end
        end
        check({name, " completed"}, seen, 1);
        if (seen) begin
            check({name, " result"}, value_out, exp_res);
            check({name, " error"}, error_out, exp_err);
            check({name, " latency"}, lat, exp_lat);
            check({name, " busy during op"}, busy_ok, 1);
            check({name, " busy at valid"}, busy_out, 0);
            @(posedge clk_in);
            #1;
            check({name, " single pulse"}, valid_out, 0);
        end
    endtask

    initial begin
        logic [15:0] rv;
        logic [15:0] rm;
        logic [15:0] re;
        int          pulses;

        vecs[0]  = '{v: 16'd4,     m: 16'd497,   e: 16'd13,    res: 16'd445,   err: 1'b0, lat: 124};
        vecs[1]  = '{v: 16'd1000,  m: 16'd7,     e: 16'd3,     res: 16'd6,     err: 1'b0, lat: 71};
        vecs[2]  = '{v: 16'd7,     m: 16'd13,    e: 16'd0,     res: 16'd1,     err: 1'b0, lat: 19};
        vecs[3]  = '{v: 16'd5,     m: 16'd1,     e: 16'd0,     res: 16'd0,     err: 1'b0, lat: 19};
        vecs[4]  = '{v: 16'd3,     m: 16'd0,     e: 16'd5,     res: 16'd0,     err: 1'b1, lat: 2};
        vecs[5]  = '{v: 16'd2,     m: 16'd1000,  e: 16'd10,    res: 16'd24,    err: 1'b0, lat: 107};
        vecs[6]  = '{v: 16'd0,     m: 16'd11,    e: 16'd5,     res: 16'd0,     err: 1'b0, lat: 89};
        vecs[7]  = '{v: 16'd3,     m: 16'd2,     e: 16'd7,     res: 16'd1,     err: 1'b0, lat: 106};
        vecs[8]  = '{v: 16'd9,     m: 16'd1,     e: 16'd4,     res: 16'd0,     err: 1'b0, lat: 72};
        vecs[9]  = '{v: 16'd65535, m: 16'd65535, e: 16'd65535, res: 16'd0,     err: 1'b0, lat: 561};
        vecs[10] = '{v: 16'd65534, m: 16'd65535, e: 16'd65535, res: 16'd65534, err: 1'b0, lat: 561};
        vecs[11] = '{v: 16'd5,     m: 16'd7,     e: 16'd1,     res: 16'd5,     err: 1'b0, lat: 36};

        rst_in      = 1'b1;
        ready_in    = 1'b0;
        abort_in    = 1'b0;
        value_in    = '0;
        modulus_in  = '0;
        exponent_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset value_out", value_out, 0);
        check("reset busy_out", busy_out, 0);
        check("reset valid_out", valid_out, 0);
        check("reset error_out", error_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].v, vecs[i].m, vecs[i].e,
                   vecs[i].res, vecs[i].err, vecs[i].lat, 1'b0);
        end

        // Abort while idle has no effect.
        @(negedge clk_in);
        abort_in = 1'b1;
        @(posedge clk_in);
        #1;
        abort_in = 1'b0;
        check("idle abort busy", busy_out, 0);
        check("idle abort valid", valid_out, 0);

        // Abort in the first SQR of 4^13 mod 497 (accept+35 .. accept+51).
        @(negedge clk_in);
        value_in    = 16'd4;
        modulus_in  = 16'd497;
        exponent_in = 16'd13;
        ready_in    = 1'b1;
        @(posedge clk_in);
        #1;
        ready_in = 1'b0;
        repeat (39) begin
            @(posedge clk_in);
            #1;
        end
        check("pre-abort busy", busy_out, 1);
        abort_in = 1'b1;
        @(posedge clk_in);
        #1;
        abort_in = 1'b0;
        check("abort busy low", busy_out, 0);
        check("abort no valid", valid_out, 0);
        check("abort value held", value_out, 5);
        run_op("after abort", 16'd2, 16'd1000, 16'd10, 16'd24, 1'b0, 107, 1'b0);

        // Requests and operand changes while busy are ignored.
        run_op("disturbed", 16'd4, 16'd497, 16'd13, 16'd445, 1'b0, 124, 1'b1);

        // Reset in the middle of an operation.
        @(negedge clk_in);
        value_in    = 16'd4;
        modulus_in  = 16'd497;
        exponent_in = 16'd13;
        ready_in    = 1'b1;
        @(posedge clk_in);
        #1;
        ready_in = 1'b0;
        repeat (30) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("mid reset value_out", value_out, 0);
        check("mid reset busy_out", busy_out, 0);
        check("mid reset valid_out", valid_out, 0);
        check("mid reset error_out", error_out, 0);
        pulses = 0;
        repeat (150) begin
            @(posedge clk_in);
            #1;
            if (valid_out || busy_out) pulses++;
        end
        check("mid reset no activity", pulses, 0);

        // Random sweep against the behavioural model.
        for (int i = 0; i < 40; i++) begin
            rv = 16'($urandom_range(0, 65535));
            rm = (i % 8 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom_range(1, 65535));
            re = (i % 2 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom_range(0, 65535));
            run_op($sformatf("rand%0d", i), rv, rm, re, model_res(rv, rm, re),
                   (rm == 0), model_lat(rm, re), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
